ddr_rd_serializer_8x1: RTL and testbench
========================================

# ddr_rd_serializer_8x1

DDR read-path serializer. It accepts one 256-bit DDR read beat (eight 32-bit words) and emits it as 32 bytes to the UART transmitter, one byte per handshake. It is the read-direction counterpart of the write-path word packer, and uses the same packing: word 0 occupies bits [255:224], word 7 occupies bits [31:0].

## Interface
Parameters:
- NUM_WORDS, 8, words per beat; fixed at 8 for this revision.
- WORD_W, 32, word width in bits; bytes per word = WORD_W/8 = 4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_rd_data  in  256  DDR read beat.
- i_rd_valid  in  1  beat valid.
- o_rd_ready  out  1  block can accept a beat (registered).
- o_byte  out  8  byte to UART TX.
- o_byte_valid  out  1  o_byte valid.
- i_byte_ready  in  1  UART TX accepts byte.
- o_word  out  32  word currently being sent (debug/test).
- o_word_idx  out  3  index of current word, 0..7.
- o_byte_idx  out  2  index of current byte within word, 0..3 (0 = bits [31:24]).
- o_busy  out  1  beat held and being sent.
- o_done  out  1  one-cycle pulse after last byte accepted.

## Operation
- Four states:
  - IDLE: o_rd_ready=1. When i_rd_valid=1, capture i_rd_data into the 256-bit shadow register, clear word_idx and byte_idx, and go to SEND.
  - SEND: o_byte_valid=1, o_busy=1. o_byte = byte byte_idx of word word_idx.
  - LAST: the final byte (word 7, byte 3) has been accepted.
  - DONE: o_done=1 for exactly one cycle, then return to IDLE.
- Byte transfer occurs when o_byte_valid && i_byte_ready.
  - On a transfer, increment byte_idx. When byte_idx wraps from 3 to 0, increment word_idx.
  - Transfer of word 7, byte 3 goes to DONE (LAST is merged into this transition).
- Send order: word 0 to word 7. Within each word, bits [31:24], then [23:16], [15:8], [7:0].
- o_word = shadow[255-32*word_idx -: 32], updated together with the indices.
- Arithmetic: word_idx is 3-bit and byte_idx is 2-bit, and both wrap naturally. No other counters.
- Boundary conditions:
  - i_rd_valid outside IDLE: ignored, not captured, no error flag. The upstream source holds its beat until o_rd_ready.
  - i_byte_ready=0 in SEND: o_byte, o_byte_valid, o_word and both indices hold stable for any number of cycles.
  - i_byte_ready=1 while o_byte_valid=0: no effect.
  - i_rd_valid=1 in the DONE cycle: not accepted, because o_rd_ready=0 in DONE.
  - Reset mid-beat: remaining bytes are discarded, no o_done pulse, and all outputs return to reset values at the next edge.
- Reset values:
  - Outputs: o_rd_ready=0, o_byte=0, o_byte_valid=0, o_word=0, o_word_idx=0, o_byte_idx=0, o_busy=0, o_done=0.
  - Internal: state=IDLE, shadow register=0.

## Timing
- o_rd_ready rises in the first cycle after rst deasserts.
- Beat accepted at edge N. At N+1: o_rd_ready=0, o_byte_valid=1, o_byte = i_rd_data[255:248].
- With i_byte_ready held high, one byte per cycle with no bubbles. The last byte is presented at N+32.
- o_done=1 at N+33 with o_byte_valid=0.
- o_rd_ready=1 at N+34, so the minimum beat-to-beat period is 34 cycles.
- Every stall cycle (i_byte_ready=0 with valid high) adds exactly one cycle to that beat.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: rst=0 for 3 cycles, then release. All outputs 0 during reset; o_rd_ready=1 one cycle after release.
- Single beat with i_byte_ready=1 and i_rd_data = bytes 0x00..0x1F, MSB first (0x0001...1F). Required response:
  - o_byte sequence 0x00,0x01,...,0x1F on consecutive cycles.
  - o_word_idx steps 0..7, each word held for 4 cycles.
  - o_done pulses exactly once at acceptance+33.
- Backpressure: toggle i_byte_ready 1,0,0,1,... with the same beat. The byte sequence is unchanged, o_byte is stable while ready=0, and o_done is delayed by exactly the number of stall cycles.
- Back-to-back beats: hold i_rd_valid=1 with beat A=all 0xAA, then beat B=all 0x55. Required response:
  - 32×0xAA, then 32×0x55.
  - Second capture exactly 34 cycles after the first.
  - i_rd_valid is ignored while busy.
- Reset mid-op: assert rst after the 10th byte is accepted. o_byte_valid=0 and o_busy=0 at the next edge, and no o_done. A new beat 0xFF.. sent after release is emitted fully and correctly.
- Word boundary: beat with word 3 = 0xDEADBEEF and other words 0. o_word=0xDEADBEEF while o_word_idx=3, with bytes 0xDE,0xAD,0xBE,0xEF at byte_idx 0..3.

Source files
------------

// File: rtl/ddr_rd_serializer_8x1.sv
// ---------------------------------------------------------------------------
// ddr_rd_serializer_8x1
//
// Takes one 256-bit DDR read beat (eight 32-bit words, word 0 in bits
// [255:224], word 7 in bits [31:0]) and sends it to the UART transmitter as
// 32 bytes, one byte per valid/ready handshake. The order is word 0 to word 7,
// and most-significant byte first within each word.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   i_rd_data     DDR read beat
//   i_rd_valid    beat valid (accepted only while o_rd_ready is high)
//   o_rd_ready    block can accept a beat (registered)
//   o_byte        byte to UART TX
//   o_byte_valid  o_byte valid
//   i_byte_ready  UART TX accepts o_byte
//   o_word        word currently being sent (debug)
//   o_word_idx    index of current word, 0..7
//   o_byte_idx    index of current byte in word, 0 = bits [31:24]
//   o_busy        beat held and being sent
//   o_done        one-cycle pulse after the last byte is accepted
//
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ddr_rd_serializer_8x1 #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] i_rd_data,
    input  logic                        i_rd_valid,
    output logic                        o_rd_ready,
    output logic [7:0]                  o_byte,
    output logic                        o_byte_valid,
    input  logic                        i_byte_ready,
    output logic [WORD_W-1:0]           o_word,
    output logic [2:0]                  o_word_idx,
    output logic [1:0]                  o_byte_idx,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int         BEAT_W  = NUM_WORDS * WORD_W;
    localparam logic [7:0] TOP_BIT = 8'(BEAT_W - 1);

    // LAST is folded into the SEND -> DONE transition; it is kept in the
    // encoding only so a stray state value still drains cleanly to DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   shadow_q;
    logic                rd_ready_q;
    logic [7:0]          byte_q;
    logic                byte_valid_q;
    logic [WORD_W-1:0]   word_q;
    logic [2:0]          word_idx_q;
    logic [1:0]          byte_idx_q;
    logic                busy_q;
    logic                done_q;

    logic                xfer;
    logic                last_xfer;
    logic [2:0]          word_idx_d;
    logic [1:0]          byte_idx_d;
    logic [7:0]          byte_d;
    logic [WORD_W-1:0]   word_d;

    // Next indices and the byte/word they select, so that the registered
    // outputs move together with the indices on each accepted byte.
    // NOTE: every signal gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        xfer       = 1'b0;
        last_xfer  = 1'b0;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;

        xfer       = (state_q == SEND) && byte_valid_q && i_byte_ready;
        last_xfer  = xfer && (word_idx_q == 3'd7) && (byte_idx_q == 2'd3);
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
            word_idx_d = word_idx_q + 3'd1;
        end

        // Byte k of the beat sits at bits [255-8k -: 8]; k = {word, byte}.
        byte_d = shadow_q[TOP_BIT - {word_idx_d, byte_idx_d, 3'b000} -: 8];
        word_d = shadow_q[TOP_BIT - {word_idx_d, 5'b00000} -: WORD_W];
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples values from before the edge, regardless of order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            rd_ready_q   <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            word_q       <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready rises one cycle after reset release, so the
                    // capture qualifies on the registered ready, not on state.
                    if (rd_ready_q && i_rd_valid) begin
                        state_q      <= SEND;
                        shadow_q     <= i_rd_data;
                        rd_ready_q   <= 1'b0;
                        byte_q       <= i_rd_data[BEAT_W-1 -: 8];
                        word_q       <= i_rd_data[BEAT_W-1 -: WORD_W];
                        byte_valid_q <= 1'b1;
                        word_idx_q   <= '0;
                        byte_idx_q   <= '0;
                        busy_q       <= 1'b1;
                    end else begin
                        rd_ready_q   <= 1'b1;
                    end
                end

                SEND: begin
                    if (xfer) begin
                        word_idx_q <= word_idx_d;
                        byte_idx_q <= byte_idx_d;
                        byte_q     <= byte_d;
                        word_q     <= word_d;
                        if (last_xfer) begin
                            state_q      <= DONE;
                            byte_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                end

                LAST: begin
                    state_q      <= DONE;
                    byte_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end

                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    rd_ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_rd_ready   = rd_ready_q;
    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_word       = word_q;
    assign o_word_idx   = word_idx_q;
    assign o_byte_idx   = byte_idx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_ddr_rd_serializer_8x1.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_serializer_8x1
//
// Directed bench for ddr_rd_serializer_8x1. Inputs are driven 1 ns after each
// rising edge and outputs are sampled at the same point, so every value seen
// is the settled result of the preceding edge. Expected bytes for each beat
// are written by hand into exp_b before the beat is streamed.
// ---------------------------------------------------------------------------
module tb_ddr_rd_serializer_8x1;

    logic         clk;
    logic         rst;
    logic [255:0] i_rd_data;
    logic         i_rd_valid;
    logic         o_rd_ready;
    logic [7:0]   o_byte;
    logic         o_byte_valid;
    logic         i_byte_ready;
    logic [31:0]  o_word;
    logic [2:0]   o_word_idx;
    logic [1:0]   o_byte_idx;
    logic         o_busy;
    logic         o_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_b [32];

    ddr_rd_serializer_8x1 dut (
        .clk          (clk),
        .rst          (rst),
        .i_rd_data    (i_rd_data),
        .i_rd_valid   (i_rd_valid),
        .o_rd_ready   (o_rd_ready),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_word       (o_word),
        .o_word_idx   (o_word_idx),
        .o_byte_idx   (o_byte_idx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All outputs packed: rd_ready, busy, byte_valid, done, word_idx,
    // byte_idx, byte, word (49 bits).
    function automatic logic [63:0] outs();
        return 64'({o_rd_ready, o_busy, o_byte_valid, o_done,
                    o_word_idx, o_byte_idx, o_byte, o_word});
    endfunction

    function automatic logic [63:0] exp_send(input int k);
        int w;
        w = k / 4;
        return 64'({1'b0, 1'b1, 1'b1, 1'b0, 3'(w), 2'(k % 4), exp_b[k],
                    exp_b[4*w], exp_b[4*w+1], exp_b[4*w+2], exp_b[4*w+3]});
    endfunction

    // Wait (bounded) for ready, present the beat, and return 1 ns after the
    // accepting edge. With hold set, i_rd_valid is left high afterwards.
    task automatic accept_beat(input string name, input logic [255:0] beat, input bit hold);
        int n;
        n = 0;
        while (o_rd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({name, " ready wait"}, 64'(o_rd_ready), 64'd1);
        i_rd_data  = beat;
        i_rd_valid = 1'b1;
        tick();
        if (!hold) i_rd_valid = 1'b0;
    endtask

    // From acceptance+1: 32 bytes on consecutive cycles, then the done pulse
    // at acceptance+33 and ready back at acceptance+34.
    task automatic stream_beat(input string name);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s byte %0d", name, k), outs(), exp_send(k));
            tick();
        end
        check({name, " done pulse"}, 64'({o_done, o_byte_valid, o_busy, o_rd_ready}), 64'b1000);
        tick();
        check({name, " after done"}, 64'({o_done, o_rd_ready}), 64'b01);
    endtask

    initial begin
        logic [255:0] beat;
        int           k;
        int           c;

        rst          = 1'b0;
        i_rd_data    = '0;
        i_rd_valid   = 1'b0;
        i_byte_ready = 1'b0;

        // Reset: all outputs zero for three cycles, ready one cycle after release.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset cycle %0d", i), outs(), 64'd0);
        end
        rst = 1'b1;
        tick();
        check("ready after release", 64'({o_rd_ready, o_byte_valid, o_busy, o_done}), 64'b1000);

        // Single beat 0x00..0x1F, MSB first, no backpressure.
        for (int i = 0; i < 32; i++) begin
            beat[255-8*i -: 8] = 8'(i);
            exp_b[i]           = 8'(i);
        end
        i_byte_ready = 1'b1;
        accept_beat("seq", beat, 1'b0);
        stream_beat("seq");

        // Backpressure with ready pattern 1,0,0,1,0,0,... on the same beat.
        // 31 of the 32 bytes see two stall cycles, so done lands 62 cycles late.
        accept_beat("bp", beat, 1'b0);
        k = 0;
        c = 0;
        while (k < 32 && c < 200) begin
            i_byte_ready = (c % 3 == 0);
            check($sformatf("bp cycle %0d", c), outs(), exp_send(k));
            tick();
            if (i_byte_ready) k++;
            c++;
        end
        check("bp cycle count", 64'(c), 64'd94);
        i_byte_ready = 1'b1;
        check("bp done pulse", 64'({o_done, o_byte_valid, o_busy, o_rd_ready}), 64'b1000);
        tick();
        check("bp after done", 64'({o_done, o_rd_ready}), 64'b01);

        // Back-to-back: valid held high; beat B sits on the bus while A is sent.
        for (int i = 0; i < 32; i++) exp_b[i] = 8'hAA;
        accept_beat("bbA", {32{8'hAA}}, 1'b1);
        i_rd_data = {32{8'h55}};
        for (int i = 0; i < 32; i++) begin
            check($sformatf("bbA byte %0d", i), outs(), exp_send(i));
            tick();
        end
        check("bbA done pulse", 64'({o_done, o_byte_valid, o_rd_ready}), 64'b100);
        tick();
        check("bb ready at +34", 64'({o_done, o_rd_ready}), 64'b01);
        tick();
        i_rd_valid = 1'b0;
        for (int i = 0; i < 32; i++) exp_b[i] = 8'h55;
        stream_beat("bbB");

        // Reset after the 10th byte is accepted.
        for (int i = 0; i < 32; i++) exp_b[i] = 8'(i);
        accept_beat("rst", beat, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("rst 11th byte shown", outs(), exp_send(10));
        rst = 1'b0;
        tick();
        check("rst outputs cleared", outs(), 64'd0);
        tick();
        check("rst no done", outs(), 64'd0);
        rst = 1'b1;
        tick();
        check("rst ready again", 64'({o_rd_ready, o_done}), 64'b10);
        for (int i = 0; i < 32; i++) exp_b[i] = 8'hFF;
        accept_beat("ff", {32{8'hFF}}, 1'b0);
        stream_beat("ff");

        // Word boundary: word 3 = 0xDEADBEEF, all other words zero.
        beat = '0;
        beat[159:128] = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) exp_b[i] = 8'h00;
        exp_b[12] = 8'hDE;
        exp_b[13] = 8'hAD;
        exp_b[14] = 8'hBE;
        exp_b[15] = 8'hEF;
        accept_beat("word3", beat, 1'b0);
        stream_beat("word3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
